mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
Parametrised multi-cycle multiply/divide unit for the multicycle CPU datapath. It generalises the fixed 32-bit Div/Mult pair to any operand WIDTH, with signed/unsigned modes on one shared iterative datapath. Results go to the HI/LO registers via the HICtrl/LOCtrl muxes. The controller FSM starts an operation with a one-cycle start pulse and waits for done.

Parameters:
WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits; must be >= 4.
CNT_W, $clog2(WIDTH), iteration-counter width; derived localparam, never overridden.

Ports:
clock  in  1  system clock; all state changes on rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  one-cycle request; sampled only in IDLE.
op  in  1  0 = multiply, 1 = divide.
signed_op  in  1  1 = two's-complement operands, 0 = unsigned.
a  in  WIDTH  multiplicand / dividend; sampled with start.
b  in  WIDTH  multiplier / divisor; sampled with start.
busy  out  1  high from the cycle after an accepted start through FIX.
done  out  1  one-cycle pulse; hi/lo are valid in the same cycle.
div_zero  out  1  one-cycle pulse with done when the divisor is 0.
hi  out  WIDTH  mult: upper product half; div: remainder.
lo  out  WIDTH  mult: lower product half; div: quotient.

Behaviour:
- Reset, synchronous, active-high: state=IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0; counter=0. Reset mid-operation aborts, and the result is lost.
- States: IDLE -> PREP -> CALC -> FIX -> DONE -> IDLE. Div-by-zero path: PREP -> DONE.
- IDLE: when start=1, latch a, b, op and signed_op, then go to PREP. When start=0, stay in IDLE.
- PREP:
  - Compute absolute values when signed_op=1.
  - Record result signs: product sign = a_msb XOR b_msb; quotient sign = same; remainder sign = a_msb.
  - Clear the 2*WIDTH accumulator and set counter=0.
  - If op=1 and b=0: go to DONE with the div_zero flag set.
- CALC: exactly WIDTH cycles, one bit per cycle. The counter increments each cycle; at counter=WIDTH-1, go to FIX.
  - Multiply: shift-add, unsigned magnitudes.
  - Divide: restoring shift-subtract, unsigned magnitudes.
- FIX:
  - Negate the 2*WIDTH product when its recorded sign=1 (signed only).
  - Negate the quotient and remainder independently by their recorded signs.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
- DONE: done=1 for one cycle. hi/lo are written at the PREP->DONE or FIX->DONE edge and hold until the next DONE.
- Division by zero: div_zero=1 with done; hi and lo keep their previous values.
- Latency, start accepted in cycle n:
  - normal operation: done in cycle n+WIDTH+3;
  - div-by-zero: done in cycle n+2.
- Signed overflow: MIN / -1 gives lo=MIN (wraps) and hi=0, with no flag.
- Unsigned mode: all WIDTH bits are magnitude; a 2*WIDTH product cannot overflow.
- start is ignored while busy=1 or in DONE; no queuing. A start in the DONE cycle itself is not accepted.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package md_pkg holds:
  - state enum: IDLE, PREP, CALC, FIX, DONE;
  - op encoding constants: OP_MULT=0, OP_DIV=1.
- One sub-module md_step: combinational single-iteration step (add-or-pass for multiply, trial-subtract for divide), parametrised by WIDTH. The top keeps the FSM, counter, sign fix-up and output registers.

Test Plan:
- WIDTH=32, mult signed, a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB, done exactly 35 cycles after the start cycle.
- mult unsigned, a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; the same pair with signed_op=1 -> hi=0, lo=1.
- div signed, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; div unsigned, a=100, b=7 -> lo=14, hi=2.
- div by zero after a prior result hi=2, lo=14: a=5, b=0 -> done and div_zero both high in cycle n+2; hi=2, lo=14 unchanged.
- div signed, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
- Control:
  - Pulse start again mid-CALC -> ignored; the original result is unchanged.
  - Assert reset mid-CALC -> next cycle busy=0, hi=lo=0, state IDLE.
  - Rerun with WIDTH=8: a=0xF9, b=0x02 signed div -> lo=0xFD, hi=0xFF, done at n+11.

Source files
------------

// File: rtl/md_pkg.sv
// Shared types and encodings for the iterative multiply/divide unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package md_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        CALC,
        FIX,
        DONE
    } md_state_e;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the CPU controller and the multiply/divide unit.
// Latency: n/a (wiring only).
// Backpressure: requester must hold off while busy or done; no queuing.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic             signed_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, signed_op, a, b,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, signed_op, a, b,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/md_step.sv
// One iteration of the shared datapath: shift-add multiply or restoring divide.
// Latency: combinational.
// Backpressure: none; evaluated every cycle, used only while iterating.
module md_step
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 op_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [WIDTH-1:0]     opnd_i,
    output logic [2*WIDTH-1:0]   acc_o
);
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] rem_sh;
    logic             rem_carry;
    logic             fits;
    logic [WIDTH-1:0] diff;

    // Multiply: acc = {partial product, remaining multiplier bits}; add when LSB set.
    assign sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, (acc_i[0] ? opnd_i : {WIDTH{1'b0}})};

    // Divide: acc = {remainder, dividend/quotient bits}; the shifted-out remainder
    // MSB means the trial subtract always fits, and the W-bit difference is exact.
    assign rem_carry = acc_i[2*WIDTH-1];
    assign rem_sh    = acc_i[2*WIDTH-2:WIDTH-1];
    assign fits      = rem_carry | (rem_sh >= opnd_i);
    assign diff      = rem_sh - opnd_i;

    // Select the next accumulator for the active operation.
    always_comb begin
        acc_o = acc_i;
        if (op_i == OP_MULT) begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end else if (fits) begin
            acc_o = {diff, acc_i[WIDTH-2:0], 1'b1};
        end else begin
            acc_o = {acc_i[2*WIDTH-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed/unsigned multiply/divide producing HI/LO for the CPU datapath.
// Latency: done WIDTH+3 cycles after the accepted start; 2 cycles on divide-by-zero.
// Backpressure: start is ignored outside IDLE; no queuing of requests.
module mult_div_unit
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic           clock,
    input  logic           reset,
    mult_div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    md_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic                 op_q, op_d, sgn_q, sgn_d;
    logic                 neg_q, neg_d, rneg_q, rneg_d;
    logic                 busy_q, busy_d, done_q, done_d, dz_q, dz_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;

    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag, quo, rem;
    logic [2*WIDTH-1:0]   prod, step_acc;

    assign a_neg = sgn_q & a_q[WIDTH-1];
    assign b_neg = sgn_q & b_q[WIDTH-1];
    assign a_mag = a_neg ? -a_q : a_q;
    assign b_mag = b_neg ? -b_q : b_q;

    // MIN magnitudes stay as 2^(W-1) unsigned, so MIN / -1 wraps back to MIN.
    assign prod = neg_q  ? -acc_q : acc_q;
    assign quo  = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    md_step #(.WIDTH(WIDTH)) u_step (
        .op_i   (op_q),
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .acc_o  (step_acc)
    );

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        sgn_d   = sgn_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    op_d    = bus.op;
                    sgn_d   = bus.signed_op;
                    state_d = PREP;
                end
            end
            PREP: begin
                neg_d  = a_neg ^ b_neg;
                rneg_d = a_neg;
                cnt_d  = '0;
                // Low half is preloaded with the operand consumed bit-by-bit.
                if (op_q == OP_MULT) begin
                    acc_d  = {{WIDTH{1'b0}}, b_mag};
                    opnd_d = a_mag;
                end else begin
                    acc_d  = {{WIDTH{1'b0}}, a_mag};
                    opnd_d = b_mag;
                end
                if (op_q == OP_DIV && b_q == '0) begin
                    state_d = DONE;
                end else begin
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = step_acc;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (op_q == OP_MULT) begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else begin
                    hi_d = rem;
                    lo_d = quo;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == PREP) || (state_d == CALC) || (state_d == FIX);
        done_d = (state_d == DONE);
        dz_d   = (state_q == PREP) && (state_d == DONE);
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 1'b0;
            sgn_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            sgn_q   <= sgn_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit at WIDTH=32 and WIDTH=8.
// Latency: checks exact done cycle relative to the accepted start.
// Backpressure: exercises starts issued while busy and in the done cycle.
module tb_mult_div_unit;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] prev_hi [2];
    logic [31:0] prev_lo [2];

    mult_div_unit_if #(.WIDTH(32)) bus32 ();
    mult_div_unit_if #(.WIDTH(8))  bus8 ();

    mult_div_unit #(.WIDTH(32)) dut32 (.clock(clk), .reset(rst), .bus(bus32));
    mult_div_unit #(.WIDTH(8))  dut8  (.clock(clk), .reset(rst), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit w8, input logic s, input logic op, input logic sgn,
                         input logic [31:0] a, input logic [31:0] b);
        if (w8) begin
            bus8.start = s; bus8.op = op; bus8.signed_op = sgn;
            bus8.a = a[7:0]; bus8.b = b[7:0];
        end else begin
            bus32.start = s; bus32.op = op; bus32.signed_op = sgn;
            bus32.a = a; bus32.b = b;
        end
    endtask

    function automatic logic get_done(input bit w8);
        return w8 ? bus8.done : bus32.done;
    endfunction

    function automatic logic get_busy(input bit w8);
        return w8 ? bus8.busy : bus32.busy;
    endfunction

    // Reference: plain signed/unsigned arithmetic on sign-extended 64-bit values.
    function automatic void model(input bit w8, input logic op, input logic sgn,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo,
                                  output logic dz);
        int          w;
        logic [63:0] mask, ua, ub, r;
        longint      sa, sb;
        w    = w8 ? 8 : 32;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'b0, a} & mask;
        ub   = {32'b0, b} & mask;
        if (sgn) begin
            sa = $signed(ua << (64 - w)) >>> (64 - w);
            sb = $signed(ub << (64 - w)) >>> (64 - w);
        end else begin
            sa = $signed(ua);
            sb = $signed(ub);
        end
        dz = 1'b0;
        if (op == 1'b0) begin
            r  = sa * sb;
            lo = r[31:0] & mask[31:0];
            r  = r >> w;
            hi = r[31:0] & mask[31:0];
        end else if (ub == 64'd0) begin
            dz = 1'b1;
            hi = prev_hi[w8];
            lo = prev_lo[w8];
        end else begin
            r  = sa / sb;
            lo = r[31:0] & mask[31:0];
            r  = sa % sb;
            hi = r[31:0] & mask[31:0];
        end
    endfunction

    task automatic run_op(input bit w8, input logic op, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo,
                          output logic dz, output int lat);
        lat = -1;
        hi  = '0;
        lo  = '0;
        dz  = 1'b0;
        @(negedge clk);
        drive(w8, 1'b1, op, sgn, a, b);
        @(negedge clk);
        drive(w8, 1'b0, op, sgn, a, b);
        check("busy_after_start", 64'(get_busy(w8)), 64'd1);
        for (int k = 1; k <= 200; k++) begin
            if (get_done(w8)) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        if (lat < 0) begin
            check("done_timeout", 64'd0, 64'd1);
        end else begin
            hi = w8 ? {24'b0, bus8.hi} : bus32.hi;
            lo = w8 ? {24'b0, bus8.lo} : bus32.lo;
            dz = w8 ? bus8.div_zero : bus32.div_zero;
            @(negedge clk);
            check("done_one_cycle", 64'(get_done(w8)), 64'd0);
        end
    endtask

    vec_t        tbl [7];
    logic [31:0] ghi, glo, ehi, elo;
    logic        gdz, edz;
    int          glat, k, ndone;
    bit          w8r;
    logic        rop, rsgn;
    logic [31:0] ra, rb;

    initial begin
        tbl[0] = '{1'b0, 1'b1, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 35};
        tbl[1] = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 35};
        tbl[2] = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 35};
        tbl[3] = '{1'b1, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 35};
        tbl[4] = '{1'b1, 1'b0, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 35};
        tbl[5] = '{1'b1, 1'b0, 32'd5,        32'd0,        32'd2,        32'd14,       1'b1, 2};
        tbl[6] = '{1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 35};

        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        prev_hi[0] = '0; prev_lo[0] = '0; prev_hi[1] = '0; prev_lo[1] = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(bus32.busy), 64'd0);
        check("reset_done", 64'(bus32.done), 64'd0);
        check("reset_dz",   64'(bus32.div_zero), 64'd0);
        check("reset_hi",   64'(bus32.hi), 64'd0);
        check("reset_lo",   64'(bus32.lo), 64'd0);
        rst = 1'b0;

        // Directed vectors at WIDTH=32.
        for (int i = 0; i < 7; i++) begin
            run_op(1'b0, tbl[i].op, tbl[i].sgn, tbl[i].a, tbl[i].b, ghi, glo, gdz, glat);
            check($sformatf("tbl%0d_hi", i),  64'(ghi),  64'(tbl[i].hi));
            check($sformatf("tbl%0d_lo", i),  64'(glo),  64'(tbl[i].lo));
            check($sformatf("tbl%0d_dz", i),  64'(gdz),  64'(tbl[i].dz));
            check($sformatf("tbl%0d_lat", i), 64'(glat), 64'(tbl[i].lat));
            if (!tbl[i].dz) begin
                prev_hi[0] = tbl[i].hi;
                prev_lo[0] = tbl[i].lo;
            end
        end

        // Start pulsed mid-calculation and again in the done cycle: both ignored.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd100, 32'd7);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd100, 32'd7);
        k = 1;
        repeat (4) begin @(negedge clk); k++; end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd9, 32'd3);
        @(negedge clk); k++;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd9, 32'd3);
        while (!bus32.done && k < 200) begin @(negedge clk); k++; end
        check("midcalc_lat", 64'(k), 64'd35);
        check("midcalc_hi",  64'(bus32.hi), 64'd2);
        check("midcalc_lo",  64'(bus32.lo), 64'd14);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd9, 32'd3);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd9, 32'd3);
        check("start_in_done_ignored", 64'(bus32.busy), 64'd0);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus32.done || bus32.busy) ndone++;
        end
        check("no_queued_op", 64'(ndone), 64'd0);
        prev_hi[0] = 32'd2; prev_lo[0] = 32'd14;

        // Reset in the middle of an operation.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h12345678, 32'h9ABCDEF0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h12345678, 32'h9ABCDEF0);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 64'(bus32.busy), 64'd0);
        check("midrst_hi",   64'(bus32.hi), 64'd0);
        check("midrst_lo",   64'(bus32.lo), 64'd0);
        check("midrst_done", 64'(bus32.done), 64'd0);
        rst = 1'b0;
        prev_hi[0] = '0; prev_lo[0] = '0; prev_hi[1] = '0; prev_lo[1] = '0;

        // WIDTH=8 signed divide.
        run_op(1'b1, 1'b1, 1'b1, 32'hF9, 32'h02, ghi, glo, gdz, glat);
        check("w8_div_hi",  64'(ghi),  64'hFF);
        check("w8_div_lo",  64'(glo),  64'hFD);
        check("w8_div_dz",  64'(gdz),  64'd0);
        check("w8_div_lat", 64'(glat), 64'd11);
        prev_hi[1] = 32'hFF; prev_lo[1] = 32'hFD;

        // Randomized operations against the arithmetic model, both widths.
        for (int i = 0; i < 260; i++) begin
            w8r  = (i >= 200);
            rop  = 1'($urandom_range(0, 1));
            rsgn = 1'($urandom_range(0, 1));
            ra   = $urandom;
            rb   = $urandom;
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: begin ra = w8r ? 32'h80 : 32'h80000000; rb = 32'hFFFFFFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: ra = 32'($urandom_range(0, 15));
                default: ;
            endcase
            model(w8r, rop, rsgn, ra, rb, ehi, elo, edz);
            run_op(w8r, rop, rsgn, ra, rb, ghi, glo, gdz, glat);
            check($sformatf("rnd%0d_hi", i),  64'(ghi),  64'(ehi));
            check($sformatf("rnd%0d_lo", i),  64'(glo),  64'(elo));
            check($sformatf("rnd%0d_dz", i),  64'(gdz),  64'(edz));
            check($sformatf("rnd%0d_lat", i), 64'(glat), edz ? 64'd2 : (w8r ? 64'd11 : 64'd35));
            if (!edz) begin
                prev_hi[w8r] = ehi;
                prev_lo[w8r] = elo;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
